// File: rtl/detector_jogada.sv
// Button front-end for the memory game: synchronizes and debounces four buttons and
// reports a single accepted press (tem_jogada/jogada) or a multi-button attempt (invalida).
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic [3:0] botoes,
  output logic       tem_jogada,
  output logic [3:0] jogada,
  output logic       invalida,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    FILTRANDO     = 2'd1,
    PULSO         = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  localparam logic [9:0] CNT_MAX = 10'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_q;
  logic [3:0] bsync_q;
  estado_t    estado_q;
  logic [9:0] cnt_q;
  logic [3:0] cand_q;
  logic [3:0] jogada_q;
  logic       tem_q;
  logic       inv_q;
  logic       unicoBotao;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      bsync_q <= 4'b0000;
    end else begin
      sync1_q <= botoes;
      bsync_q <= sync1_q;
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign unicoBotao = (bsync_q != 4'b0000) && ((bsync_q & (bsync_q - 4'd1)) == 4'b0000);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= 10'd0;
      cand_q   <= 4'b0000;
      jogada_q <= 4'b0000;
      tem_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      tem_q <= 1'b0;
      inv_q <= 1'b0;
      if (zera) begin
        estado_q <= ESPERA_SOLTAR;
        cnt_q    <= 10'd0;
        cand_q   <= 4'b0000;
        jogada_q <= 4'b0000;
      end else begin
        case (estado_q)
          OCIOSO: begin
            if (bsync_q != 4'b0000) begin
              cnt_q <= 10'd0;
              if (unicoBotao) begin
                estado_q <= FILTRANDO;
                cand_q   <= bsync_q;
              end else begin
                estado_q <= ESPERA_SOLTAR;
                inv_q    <= 1'b1;
              end
            end
          end
          FILTRANDO: begin
            if (bsync_q == 4'b0000) begin
              estado_q <= OCIOSO;
              cnt_q    <= 10'd0;
            end else if (bsync_q != cand_q) begin
              estado_q <= ESPERA_SOLTAR;
              cnt_q    <= 10'd0;
              inv_q    <= 1'b1;
            end else if (cnt_q == CNT_MAX) begin
              estado_q <= PULSO;
              jogada_q <= cand_q;
              tem_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 10'd1;
            end
          end
          PULSO: begin
            estado_q <= ESPERA_SOLTAR;
            cnt_q    <= 10'd0;
          end
          ESPERA_SOLTAR: begin
            // Any activity restarts the release filter, so a held button never re-arms.
            if (bsync_q != 4'b0000) begin
              cnt_q <= 10'd0;
            end else if (cnt_q == CNT_MAX) begin
              estado_q <= OCIOSO;
              cnt_q    <= 10'd0;
            end else begin
              cnt_q <= cnt_q + 10'd1;
            end
          end
          default: begin
            estado_q <= OCIOSO;
            cnt_q    <= 10'd0;
          end
        endcase
      end
    end
  end

  assign tem_jogada = tem_q;
  assign jogada     = jogada_q;
  assign invalida   = inv_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_detector_jogada;

  localparam int D = 4;
  localparam int IDLE = 0, FILTER = 1, PULSE = 2, WAITREL = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zera = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic       invalida;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  int pulseCount = 0;
  int invCount = 0;
  int lastPulseEdge = -1;

  logic [3:0] mS1 = 4'b0000, mS2 = 4'b0000, mB = 4'b0000, mCand = 4'b0000, mJog = 4'b0000;
  int mPhase = IDLE;
  int mCnt = 0;
  bit mTem = 1'b0, mInv = 1'b0;

  int e, k, kind, len;
  logic [3:0] pat;

  detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock),
    .reset(reset),
    .zera(zera),
    .botoes(botoes),
    .tem_jogada(tem_jogada),
    .jogada(jogada),
    .invalida(invalida),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Reference: the FSM sees the buttons two edges late, then tracks how long the
  // single candidate has been steady and how long the buttons have been released.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mS1 = 4'b0000; mS2 = 4'b0000; mCand = 4'b0000; mJog = 4'b0000;
      mPhase = IDLE; mCnt = 0; mTem = 1'b0; mInv = 1'b0;
    end else begin
      mB = mS2;
      mS2 = mS1;
      mS1 = botoes;
      mTem = 1'b0;
      mInv = 1'b0;
      if (zera) begin
        mJog = 4'b0000; mCand = 4'b0000; mCnt = 0; mPhase = WAITREL;
      end else if (mPhase == IDLE) begin
        if ($countones(mB) == 1) begin
          mPhase = FILTER; mCand = mB; mCnt = 0;
        end else if ($countones(mB) > 1) begin
          mPhase = WAITREL; mCnt = 0; mInv = 1'b1;
        end
      end else if (mPhase == FILTER) begin
        if (mB == 4'b0000) begin
          mPhase = IDLE; mCnt = 0;
        end else if (mB != mCand) begin
          mPhase = WAITREL; mCnt = 0; mInv = 1'b1;
        end else if (mCnt + 1 == D) begin
          mPhase = PULSE; mJog = mCand; mTem = 1'b1;
        end else begin
          mCnt = mCnt + 1;
        end
      end else if (mPhase == PULSE) begin
        mPhase = WAITREL; mCnt = 0;
      end else begin
        if (mB != 4'b0000) mCnt = 0;
        else if (mCnt + 1 == D) begin mPhase = IDLE; mCnt = 0; end
        else mCnt = mCnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("tem_jogada", int'(tem_jogada), int'(mTem));
    checkOutput("invalida", int'(invalida), int'(mInv));
    checkOutput("jogada", int'(jogada), int'(mJog));
    checkOutput("db_estado", int'(db_estado), mPhase);
    if (tem_jogada) begin
      pulseCount++;
      lastPulseEdge = edgeCount;
    end
    if (invalida) invCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input int n);
    botoes = p;
    waitCycles(n);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    checkOutput("reset db_estado", int'(db_estado), 0);
    checkOutput("reset jogada", int'(jogada), 0);

    // Scenario 1: clean press, exact latency and state sequence.
    pulseCount = 0;
    botoes = 4'b0010;
    e = edgeCount + 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock); #1;
      k = edgeCount - e;
      if (k == 1) checkOutput("s1 db idle", int'(db_estado), 0);
      if (k == 2) checkOutput("s1 db filter", int'(db_estado), 1);
      if (k == 5) checkOutput("s1 db still filter", int'(db_estado), 1);
      if (k == 6) checkOutput("s1 db pulse", int'(db_estado), 2);
      if (k == 6) checkOutput("s1 tem high", int'(tem_jogada), 1);
      if (k == 7) checkOutput("s1 db wait", int'(db_estado), 3);
      if (k == 7) checkOutput("s1 tem low", int'(tem_jogada), 0);
    end
    checkOutput("s1 pulse edge", lastPulseEdge - e, 6);
    checkOutput("s1 pulse count", pulseCount, 1);
    checkOutput("s1 jogada", int'(jogada), 2);
    applyStimulus(4'b0000, 8);

    // Scenario 2: bouncing button, then stable.
    pulseCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 4'b0100 : 4'b0000, 2);
    checkOutput("s2 no pulse bouncing", pulseCount, 0);
    applyStimulus(4'b0100, 12);
    checkOutput("s2 pulse count", pulseCount, 1);
    checkOutput("s2 jogada", int'(jogada), 4);
    applyStimulus(4'b0000, 8);

    // Scenario 3: two buttons rejected, then a normal press.
    pulseCount = 0;
    invCount = 0;
    applyStimulus(4'b1001, 6);
    checkOutput("s3 invalida count", invCount, 1);
    checkOutput("s3 no pulse", pulseCount, 0);
    checkOutput("s3 jogada kept", int'(jogada), 4);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0001, 10);
    checkOutput("s3 pulse count", pulseCount, 1);
    checkOutput("s3 jogada", int'(jogada), 1);
    applyStimulus(4'b0000, 8);

    // Scenario 4: long hold, short release, re-press.
    pulseCount = 0;
    applyStimulus(4'b1000, 50);
    checkOutput("s4 single pulse", pulseCount, 1);
    applyStimulus(4'b0000, 2);
    applyStimulus(4'b1000, 20);
    checkOutput("s4 no repeat", pulseCount, 1);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b1000, 12);
    checkOutput("s4 second pulse", pulseCount, 2);
    checkOutput("s4 jogada", int'(jogada), 8);
    applyStimulus(4'b0000, 8);

    // Scenario 5: clear while a button is held.
    pulseCount = 0;
    applyStimulus(4'b0010, 10);
    checkOutput("s5 first pulse", pulseCount, 1);
    checkOutput("s5 jogada before clear", int'(jogada), 2);
    applyStimulus(4'b0001, 3);
    zera = 1'b1;
    waitCycles(1);
    zera = 1'b0;
    checkOutput("s5 jogada cleared", int'(jogada), 0);
    applyStimulus(4'b0001, 10);
    checkOutput("s5 no pulse held", pulseCount, 1);
    applyStimulus(4'b0000, 8);
    applyStimulus(4'b0001, 10);
    checkOutput("s5 pulse after release", pulseCount, 2);
    checkOutput("s5 jogada", int'(jogada), 1);
    applyStimulus(4'b0000, 8);

    // Scenario 6: asynchronous reset during filtering and during the pulse.
    pulseCount = 0;
    botoes = 4'b0010;
    repeat (5) @(posedge clock);
    #1 checkOutput("s6 in filter", int'(db_estado), 1);
    #1 reset = 1'b1;
    #1 checkOutput("s6 db after reset", int'(db_estado), 0);
    checkOutput("s6 jogada after reset", int'(jogada), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (7) @(posedge clock);
    #1 checkOutput("s6 in pulse", int'(db_estado), 2);
    #1 reset = 1'b1;
    #1 checkOutput("s6 tem after reset", int'(tem_jogada), 0);
    checkOutput("s6 jogada after pulse reset", int'(jogada), 0);
    checkOutput("s6 db after pulse reset", int'(db_estado), 0);
    botoes = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("s6 no pulse seen", pulseCount, 0);

    // Randomized run against the model.
    for (int s = 0; s < 400; s++) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      case (kind)
        0, 1, 2, 3: begin
          pat = 4'b0001 << $urandom_range(0, 3);
          applyStimulus(pat, len);
        end
        4, 5: applyStimulus(4'b0000, len);
        6: begin
          pat = 4'($urandom);
          while ($countones(pat) < 2) pat = 4'($urandom);
          applyStimulus(pat, len);
        end
        7: begin
          pat = 4'b0001 << $urandom_range(0, 3);
          for (int j = 0; j < len; j++) applyStimulus(j[0] ? 4'b0000 : pat, $urandom_range(1, 3));
        end
        8: begin
          zera = 1'b1;
          botoes = 4'($urandom);
          waitCycles(1);
          zera = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 5) == 0) applyReset();
          else applyStimulus(4'($urandom), len);
        end
      endcase
    end
    applyStimulus(4'b0000, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
